keystream_serialiser: RTL
=========================

// Module: keystream_serialiser
// PURPOSE
//  Converts ChaCha20 keystream blocks (16 x 32-bit words) into a byte-oriented
//  valid/ready stream of OUT_BYTES bytes per beat for the XOR/concatenator stage.
//  Successor to the fixed 32->8 serialiser: adds handshaking on both sides,
//  2-deep block buffering, a selectable byte order, and a per-block truncation
//  length so the final (partial) keystream block of a message is emitted exactly.
// PARAMETERS
//  WORD_W     32  width of one keystream word (fixed at 32 for ChaCha20)
//  NUM_WORDS  16  words per block
//  OUT_BYTES  1   bytes per output beat; legal values 1, 2, 4
//  BYTE_ORDER 0   0 = RFC 8439: word 0 first, LS byte first; 1 = legacy: word 15 first, MS byte first
// PORTS
//  clk        in   1              clock; all logic rising-edge
//  rst        in   1              synchronous, active-high reset
//  in_block   in   16x32          keystream block, word_t [NUM_WORDS-1:0]
//  in_len     in   7              valid bytes in this block, 1..64 (0 is treated as 64)
//  in_valid   in   1              in_block/in_len valid
//  in_ready   out  1              buffer slot free; block accepted when in_valid & in_ready
//  out_data   out  8*OUT_BYTES    output bytes; lane 0 = [7:0] = earliest byte in stream order
//  out_keep   out  OUT_BYTES      per-lane byte valid; all ones except possibly on out_last beat
//  out_valid  out  1              out_data valid
//  out_ready  in   1              downstream accepts; beat transfers when out_valid & out_ready
//  out_last   out  1              final beat of the current block
// BEHAVIOUR
//  Reset: in_ready=0 during rst, 1 the cycle after; out_valid=0, out_last=0,
//   out_keep=0, out_data=0; both buffer slots empty; beat counter=0.
//  Storage: two block slots (ACTIVE being shifted, PENDING waiting), each holding
//   block + len. in_ready = !PENDING_full (registered, no comb path from out_ready).
//  FSM: EMPTY (no ACTIVE) -> STREAM on accept; STREAM -> STREAM on last-beat
//   handshake when PENDING full (PENDING promoted, zero bubble); STREAM -> EMPTY on
//   last-beat handshake with PENDING empty and no same-cycle accept.
//  Latency: block accepted in cycle N while EMPTY -> first beat out_valid in N+1.
//  Beats per block = ceil(len/OUT_BYTES); beat counter advances only on handshake.
//  out_keep on last beat = low (len mod OUT_BYTES, or OUT_BYTES if 0) lanes set;
//   unused lanes of out_data driven 0.
//  Byte k of block (k = 0..63): BYTE_ORDER 0 -> word k/4, bits [8*(k%4)+:8];
//   BYTE_ORDER 1 -> word 15-k/4, bits [31-8*(k%4)-:8].
//  Stall: out_valid && !out_ready -> out_data/out_keep/out_last held stable.
//  Simultaneous accept and last-beat handshake with PENDING empty: new block goes
//   straight to ACTIVE, next beat is its byte 0 the following cycle.
//  Simultaneous accept and last-beat handshake with PENDING full: PENDING -> ACTIVE,
//   new block -> PENDING (in_ready was 1 only if PENDING free, so this cannot occur).
//  rst mid-block: all buffered data discarded, no out_last emitted for that block.
//  out_valid never drops without a handshake (AXI-stream rule); in_block/in_len
//   sampled only on accept.
// STRUCTURE
//  chacha_pkg: word_t (logic [31:0]), CHACHA_BLOCK_WORDS=16, CHACHA_BLOCK_BYTES=64,
//   block_t (word_t [15:0]).
//  One sub-module: ks_byte_select - combinational pick of OUT_BYTES bytes from a
//   block given byte index, BYTE_ORDER and keep mask. FSM, slots, counter stay in top.
// TESTING
//  1. OUT_BYTES=1, ORDER 0, block word i = 32'h03020100 + 32'h04040404*i, len=64,
//     out_ready=1 -> 64 beats bytes 0x00..0x3F in order, out_last on beat 64 only.
//  2. Same block, ORDER 1 -> first beat 0x3F, then 0x3E ... last 0x00 on beat 64.
//  3. OUT_BYTES=4, len=10 -> 3 beats: 0x03020100, 0x07060504, 0x00000908 with
//     out_keep 4'b1111, 4'b1111, 4'b0011; out_last on beat 3.
//  4. Back-to-back 3 blocks offered continuously, out_ready=1 -> 192 contiguous
//     beats, no bubble, in_ready low while both slots full.
//  5. Random out_ready (50%) -> data/keep/last stable whenever valid & !ready;
//     scoreboard byte stream matches reference model.
//  6. Assert rst at beat 20 of a block -> next cycle out_valid=0; next block starts
//     at byte 0; len=0 block yields 64 bytes (OUT_BYTES=1).

Source files
------------

// File: rtl/chacha_pkg.sv
// chacha_pkg: ChaCha20 keystream word/block types and FSM state shared by the serialiser.
package chacha_pkg;
  localparam int CHACHA_BLOCK_WORDS = 16;
  localparam int CHACHA_BLOCK_BYTES = 64;
  typedef logic [31:0] word_t;
  typedef word_t [CHACHA_BLOCK_WORDS-1:0] block_t;
  typedef enum logic {EMPTY, STREAM} ks_state_e;
endpackage

// File: rtl/ks_byte_select.sv
// ks_byte_select: combinational pick of OUT_BYTES stream-order bytes from a keystream block.
module ks_byte_select
  import chacha_pkg::*;
#(
  parameter int OUT_BYTES  = 1,
  parameter bit BYTE_ORDER = 1'b0
) (
  input  block_t                 blk_i,
  input  logic [5:0]             idx_i,
  input  logic [OUT_BYTES-1:0]   keep_i,
  output logic [8*OUT_BYTES-1:0] data_o
);
  logic [8*CHACHA_BLOCK_BYTES-1:0] flat;
  assign flat = blk_i;
  // Legacy order is the exact byte reversal of the flattened block.
  for (genvar j = 0; j < OUT_BYTES; j++) begin : g_lane
    logic [5:0] k;
    logic [5:0] sel;
    assign k   = idx_i + 6'(j);
    assign sel = BYTE_ORDER ? ~k : k;
    assign data_o[8*j+:8] = keep_i[j] ? flat[{sel, 3'b000} +: 8] : 8'h00;
  end
endmodule

// File: rtl/keystream_serialiser.sv
// keystream_serialiser: 2-slot buffered ChaCha20 block to byte-stream serialiser with
// valid/ready on both sides, selectable byte order and per-block truncation.
module keystream_serialiser
  import chacha_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int NUM_WORDS  = 16,
  parameter int OUT_BYTES  = 1,
  parameter bit BYTE_ORDER = 1'b0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_WORDS-1:0][WORD_W-1:0]  in_block,
  input  logic [6:0]                        in_len,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [8*OUT_BYTES-1:0]            out_data,
  output logic [OUT_BYTES-1:0]              out_keep,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last
);
  ks_state_e state_q, state_d;
  block_t act_blk_q, act_blk_d, pend_blk_q, pend_blk_d;
  logic [6:0] act_len_q, act_len_d, pend_len_q, pend_len_d, beat_q, beat_d;
  logic [6:0] pos, in_len_eff;
  logic pend_full_q, pend_full_d;
  logic accept, hs, is_last, last_hs, load_in, load_pend, load_new_pend;
  logic [OUT_BYTES-1:0] keep;
  assign in_len_eff = (in_len == 7'd0) ? 7'(CHACHA_BLOCK_BYTES) : in_len;
  assign in_ready   = !pend_full_q && !rst;
  assign out_valid  = (state_q == STREAM);
  assign pos        = 7'(beat_q * OUT_BYTES);
  assign is_last    = (pos + 7'(OUT_BYTES)) >= act_len_q;
  assign out_last   = out_valid && is_last;
  assign out_keep   = keep;
  always_comb begin
    keep = '0;
    for (int j = 0; j < OUT_BYTES; j++) keep[j] = out_valid && ((pos + 7'(j)) < act_len_q);
  end
  always_comb begin
    accept        = in_valid && in_ready;
    hs            = out_valid && out_ready;
    last_hs       = hs && is_last;
    load_pend     = last_hs && pend_full_q;
    load_in       = accept && (state_q == EMPTY || (last_hs && !pend_full_q));
    load_new_pend = accept && !load_in;
    pend_full_d   = load_new_pend || (pend_full_q && !load_pend);
    act_blk_d     = load_in ? block_t'(in_block) : load_pend ? pend_blk_q : act_blk_q;
    act_len_d     = load_in ? in_len_eff : load_pend ? pend_len_q : act_len_q;
    pend_blk_d    = load_new_pend ? block_t'(in_block) : pend_blk_q;
    pend_len_d    = load_new_pend ? in_len_eff : pend_len_q;
    beat_d        = last_hs ? 7'd0 : hs ? beat_q + 7'd1 : beat_q;
    state_d       = (load_in || load_pend || (out_valid && !last_hs)) ? STREAM : EMPTY;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      pend_full_q <= 1'b0;
      beat_q      <= 7'd0;
    end else begin
      state_q     <= state_d;
      pend_full_q <= pend_full_d;
      beat_q      <= beat_d;
    end
  end
  // Payload slots need no reset: they are only observed while the control state marks them full.
  always_ff @(posedge clk) begin
    act_blk_q  <= act_blk_d;
    act_len_q  <= act_len_d;
    pend_blk_q <= pend_blk_d;
    pend_len_q <= pend_len_d;
  end
  ks_byte_select #(.OUT_BYTES(OUT_BYTES), .BYTE_ORDER(BYTE_ORDER)) u_sel (
    .blk_i  (act_blk_q),
    .idx_i  (pos[5:0]),
    .keep_i (keep),
    .data_o (out_data)
  );
endmodule
